// File: rtl/if_fetch_unit.sv
// IF stage: PC register, next-PC selection, single-outstanding SRAM-like instruction fetch
// and a small output FIFO that feeds the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_PCWr,
  input  logic        ID_Redirect,
  input  logic [31:0] ID_Target,
  input  logic        WB_Flush,
  input  logic [31:0] WB_Target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        IF_Valid,
  input  logic        ID_Ready,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Instr,
  output logic        IF_WrongAddr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t             state, state_next;
  logic [31:0]        pc, pc_next;
  logic [31:0]        fetch_pc;
  logic               discard;

  logic [31:0]        fifo_pc    [FIFO_DEPTH];
  logic [31:0]        fifo_instr [FIFO_DEPTH];
  logic               fifo_wa    [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               redirect, misaligned, space, issue_ok, handshake;
  logic               mis_push, data_push, push, pop;
  logic [31:0]        push_pc, push_instr;

  assign redirect   = WB_Flush | ID_Redirect;
  assign misaligned = pc[1:0] != 2'b00;
  assign space      = count < CNT_W'(FIFO_DEPTH);
  assign issue_ok   = IF_PCWr & space;
  assign handshake  = inst_req & inst_addr_ok;

  // A redirect squashes anything fetched this cycle: it belongs to the wrong path.
  assign mis_push   = (state == S_REQ) & issue_ok & misaligned & ~redirect;
  assign data_push  = (state == S_WAIT) & inst_data_ok & ~discard & ~redirect;
  assign push       = mis_push | data_push;
  assign push_pc    = mis_push ? pc : fetch_pc;
  assign push_instr = mis_push ? 32'h0 : inst_rdata;
  assign pop        = IF_Valid & ID_Ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_REQ;
    else      state <= state_next;
  end

  // FSM next-state
  always_comb begin
    state_next = state;
    case (state)
      S_REQ:  if (handshake)    state_next = S_WAIT;
      S_WAIT: if (inst_data_ok) state_next = S_REQ;
      default:                  state_next = S_REQ;
    endcase
  end

  // FSM outputs; request is held low while reset is asserted
  always_comb begin
    inst_req = 1'b0;
    if (state == S_REQ)
      inst_req = rst & issue_ok & ~misaligned;
  end

  assign inst_addr = pc;

  always_comb begin
    if (WB_Flush)                  pc_next = WB_Target;
    else if (ID_Redirect)          pc_next = ID_Target;
    else if (handshake | mis_push) pc_next = pc + 32'd4;
    else                           pc_next = pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      pc <= pc_next;
      // Remember to drop the response of a fetch that was issued on the old path.
      if (state == S_WAIT) discard <= inst_data_ok ? 1'b0 : (discard | redirect);
      else                 discard <= handshake & redirect;
    end
  end

  always_ff @(posedge clk) begin
    if (handshake) fetch_pc <= pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= push_pc;
      fifo_instr[wr_ptr] <= push_instr;
      fifo_wa[wr_ptr]    <= mis_push;
    end
  end

  assign IF_Valid     = count != '0;
  assign IF_PC        = IF_Valid ? fifo_pc[rd_ptr]    : 32'h0;
  assign IF_Instr     = IF_Valid ? fifo_instr[rd_ptr] : 32'h0;
  assign IF_WrongAddr = IF_Valid & fifo_wa[rd_ptr];

endmodule
